// File: rtl/imem_boot_ctrl.sv
// Boot loader that owns the imem port: receives a length-prefixed program over UART,
// writes it word by word, acknowledges, then hands the port to the fetch stage.
module imem_boot_ctrl #(
  parameter int          ADDR_W   = 12,
  parameter logic [7:0]  ACK_BYTE = 8'hAA
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  input  logic              ack_ready,
  output logic              ack_valid,
  output logic [7:0]        ack_data,
  input  logic [31:0]       fetch_raddr,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              imem_we,
  output logic              core_run,
  output logic              load_err
);

  typedef enum logic [2:0] {S_LEN, S_LOAD, S_ACK, S_RUN, S_ERR} state_t;

  localparam logic [32:0] DEPTH = 33'(1) << ADDR_W;

  state_t            state_reg, state_next;
  logic [1:0]        byte_cnt_reg;
  logic [31:0]       shift_reg;
  logic [31:0]       len_reg;
  logic [ADDR_W:0]   wr_ptr_reg;
  logic              imem_we_reg;
  logic [31:0]       imem_wdata_reg;

  logic              collecting;
  logic              word_done;
  logic [31:0]       word;
  logic [31:0]       wr_count_next;
  logic              unused_raddr_bits;

  assign collecting    = (state_reg == S_LEN) || (state_reg == S_LOAD);
  assign word_done     = rx_valid && collecting && (byte_cnt_reg == 2'd3);
  // Little-endian: bytes enter at the top and shift down, so byte 1 ends in [7:0].
  assign word          = {rx_data, shift_reg[31:8]};
  assign wr_count_next = 32'(wr_ptr_reg) + 32'd1;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_LEN: begin
        if (word_done) begin
          if (word == 32'd0)              state_next = S_ACK;
          else if ({1'b0, word} > DEPTH)  state_next = S_ERR;
          else                            state_next = S_LOAD;
        end
      end
      S_LOAD: begin
        if (word_done && (wr_count_next == len_reg)) state_next = S_ACK;
      end
      S_ACK: begin
        if (ack_ready) state_next = S_RUN;
      end
      default: state_next = state_reg;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg      <= S_LEN;
      byte_cnt_reg   <= 2'd0;
      shift_reg      <= 32'd0;
      len_reg        <= 32'd0;
      wr_ptr_reg     <= '0;
      imem_we_reg    <= 1'b0;
      imem_wdata_reg <= 32'd0;
    end else begin
      state_reg   <= state_next;
      imem_we_reg <= 1'b0;
      if (rx_valid && collecting) begin
        byte_cnt_reg <= byte_cnt_reg + 2'd1;
        shift_reg    <= word;
      end
      if (word_done && (state_reg == S_LEN)) len_reg <= word;
      if (word_done && (state_reg == S_LOAD)) begin
        imem_we_reg    <= 1'b1;
        imem_wdata_reg <= word;
      end
      // Pointer advances at the end of the write cycle so the write sees the old value.
      if (imem_we_reg) wr_ptr_reg <= wr_ptr_reg + 1'b1;
    end
  end

  assign imem_we    = imem_we_reg;
  assign imem_wdata = imem_wdata_reg;
  assign imem_addr  = (state_reg == S_RUN) ? fetch_raddr[ADDR_W+1:2] : wr_ptr_reg[ADDR_W-1:0];
  assign ack_valid  = (state_reg == S_ACK);
  assign ack_data   = ACK_BYTE;
  assign core_run   = (state_reg == S_RUN);
  assign load_err   = (state_reg == S_ERR);

  assign unused_raddr_bits = ^{fetch_raddr[31:ADDR_W+2], fetch_raddr[1:0]};

endmodule

// File: tb/tb_imem_boot_ctrl.sv
// Directed bench for imem_boot_ctrl: load, empty load, oversize error, ack stall,
// run pass-through, reset mid-load and a full-depth load.
module tb_imem_boot_ctrl;

  localparam int ADDR_W = 12;

  logic              clk = 1'b0;
  logic              rstn = 1'b0;
  logic              rx_valid = 1'b0;
  logic [7:0]        rx_data = 8'd0;
  logic              ack_ready = 1'b0;
  logic              ack_valid;
  logic [7:0]        ack_data;
  logic [31:0]       fetch_raddr = 32'd0;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              imem_we;
  logic              core_run;
  logic              load_err;

  int errors = 0;
  int checks = 0;

  logic [31:0] wr_addr_q[$];
  logic [31:0] wr_data_q[$];

  imem_boot_ctrl #(.ADDR_W(ADDR_W), .ACK_BYTE(8'hAA)) dut (
    .clk(clk), .rstn(rstn),
    .rx_valid(rx_valid), .rx_data(rx_data),
    .ack_ready(ack_ready), .ack_valid(ack_valid), .ack_data(ack_data),
    .fetch_raddr(fetch_raddr), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .imem_we(imem_we),
    .core_run(core_run), .load_err(load_err)
  );

  always #5 clk = ~clk;

  // Record every imem write away from the active edge.
  always @(negedge clk) begin
    if (imem_we) begin
      wr_addr_q.push_back(32'(imem_addr));
      wr_data_q.push_back(imem_wdata);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end else begin
      $display("ok   %s: 0x%08h", tag, obs);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    send_byte(w[7:0]);
    send_byte(w[15:8]);
    send_byte(w[23:16]);
    send_byte(w[31:24]);
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    #1;
    chk("rst_imem_we",   32'(imem_we),   32'd0);
    chk("rst_core_run",  32'(core_run),  32'd0);
    chk("rst_ack_valid", 32'(ack_valid), 32'd0);
    chk("rst_load_err",  32'(load_err),  32'd0);
    chk("rst_imem_addr", 32'(imem_addr), 32'd0);
    chk("rst_imem_wdata", imem_wdata,    32'd0);
    tick();
    rstn = 1'b1;
    tick();
    wr_addr_q.delete();
    wr_data_q.delete();
  endtask

  initial begin
    logic [31:0] prog [3];
    prog[0] = 32'h00000013;
    prog[1] = 32'h00100093;
    prog[2] = 32'hFFDFF06F;

    tick();
    do_reset();

    // Three-word load, 16 back-to-back bytes, ack_ready already high.
    ack_ready = 1'b1;
    send_word(32'd3);
    for (int i = 0; i < 3; i++) send_word(prog[i]);
    chk("t1_last_we",     32'(imem_we),   32'd1);
    chk("t1_ack_valid",   32'(ack_valid), 32'd1);
    chk("t1_ack_data",    32'(ack_data),  32'h000000AA);
    chk("t1_run_pre",     32'(core_run),  32'd0);
    tick();
    chk("t1_core_run",    32'(core_run),  32'd1);
    chk("t1_ack_drop",    32'(ack_valid), 32'd0);
    chk("t1_nwrites",     32'(wr_addr_q.size()), 32'd3);
    for (int i = 0; i < 3 && i < wr_addr_q.size(); i++) begin
      chk($sformatf("t1_addr%0d", i), wr_addr_q[i], 32'(i));
      chk($sformatf("t1_data%0d", i), wr_data_q[i], prog[i]);
    end

    // RUN: fetch address pass-through, rx bytes ignored.
    fetch_raddr = 32'h00000010;
    #1;
    chk("run_addr", 32'(imem_addr), 32'd4);
    fetch_raddr = 32'h00003FFC;
    #1;
    chk("run_addr_top", 32'(imem_addr), 32'd4095);
    send_word(32'h12345678);
    send_word(32'h9ABCDEF0);
    chk("run_we",      32'(imem_we), 32'd0);
    chk("run_nwrites", 32'(wr_addr_q.size()), 32'd3);
    chk("run_stays",   32'(core_run), 32'd1);
    fetch_raddr = 32'd0;

    // len=0 with ack stalled for 10 cycles.
    do_reset();
    ack_ready = 1'b0;
    send_word(32'd0);
    chk("t2_ack_valid", 32'(ack_valid), 32'd1);
    for (int i = 0; i < 10; i++) tick();
    chk("t2_ack_hold", 32'(ack_valid), 32'd1);
    chk("t2_run_hold", 32'(core_run),  32'd0);
    ack_ready = 1'b1;
    tick();
    chk("t2_core_run", 32'(core_run),  32'd1);
    chk("t2_ack_drop", 32'(ack_valid), 32'd0);
    chk("t2_nwrites",  32'(wr_addr_q.size()), 32'd0);

    // Oversize length: one past the depth.
    do_reset();
    send_word(32'h00001001);
    chk("t3_load_err", 32'(load_err),  32'd1);
    chk("t3_run",      32'(core_run),  32'd0);
    send_word(32'h11111111);
    send_word(32'h22222222);
    tick();
    chk("t3_nwrites",  32'(wr_addr_q.size()), 32'd0);
    chk("t3_err_stay", 32'(load_err),  32'd1);
    chk("t3_ack",      32'(ack_valid), 32'd0);

    // Reset after a partial load, then a clean one-word load.
    do_reset();
    send_word(32'd2);
    send_byte(8'h55);
    send_byte(8'h66);
    do_reset();
    ack_ready = 1'b1;
    send_word(32'd1);
    send_word(32'hDEADBEEF);
    chk("t4_ack_valid", 32'(ack_valid), 32'd1);
    tick();
    chk("t4_core_run", 32'(core_run), 32'd1);
    chk("t4_nwrites",  32'(wr_addr_q.size()), 32'd1);
    if (wr_addr_q.size() >= 1) begin
      chk("t4_addr", wr_addr_q[0], 32'd0);
      chk("t4_data", wr_data_q[0], 32'hDEADBEEF);
    end

    // Full-depth load: len == 2^ADDR_W is legal and ends at the last address.
    do_reset();
    ack_ready = 1'b0;
    send_word(32'd4096);
    chk("t5_no_err", 32'(load_err), 32'd0);
    for (int i = 0; i < 4096; i++) begin
      send_word(32'hA5000000 | 32'(i));
      if (i == 4094) chk("t5_not_done", 32'(ack_valid), 32'd0);
    end
    chk("t5_ack_valid", 32'(ack_valid), 32'd1);
    tick();
    chk("t5_nwrites", 32'(wr_addr_q.size()), 32'd4096);
    if (wr_addr_q.size() == 4096) begin
      chk("t5_addr_first", wr_addr_q[0],    32'd0);
      chk("t5_addr_last",  wr_addr_q[4095], 32'd4095);
      chk("t5_data_mid",   wr_data_q[2048], 32'hA5000800);
      chk("t5_data_last",  wr_data_q[4095], 32'hA5000FFF);
    end
    ack_ready = 1'b1;
    tick();
    chk("t5_core_run", 32'(core_run), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
